// File: rtl/instr_fetch_dispatch_fsm_pkg.sv
// Shared definitions for the fetch/decode/dispatch controller: state encoding,
// opcode classes, control opcodes and start-vector bit positions.
package instr_fetch_dispatch_fsm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // Opcode class lives in opcode[5:4]
    localparam logic [1:0] CLS_ALUREG = 2'b00;
    localparam logic [1:0] CLS_ALUINM = 2'b01;
    localparam logic [1:0] CLS_MOV    = 2'b10;
    localparam logic [1:0] CLS_CTRL   = 2'b11;

    // Control opcodes handled inside the controller itself
    localparam logic [5:0] OP_JMP  = 6'b110000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    // One-hot start vector layout, one bit per downstream execution FSM
    localparam int START_W      = 3;
    localparam int START_ALUREG = 0;
    localparam int START_ALUINM = 1;
    localparam int START_MOV    = 2;

    typedef struct packed {
        logic [1:0]         cls;
        logic [START_W-1:0] start;
        logic               is_jmp;
        logic               is_halt;
        logic               is_illegal;
    } decode_t;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational opcode decoder: class, one-hot start vector and the
// control-opcode flags (jump, halt, illegal).
module instr_decoder
    import instr_fetch_dispatch_fsm_pkg::*;
(
    input  logic [5:0] opcode,
    output decode_t    dec
);

    // Classify the opcode and select the execution FSM it dispatches to
    always_comb begin
        // NOTE: the whole output is defaulted first so no path through the case can infer a latch.
        dec     = '0;
        dec.cls = opcode[5:4];
        case (opcode[5:4])
            CLS_ALUREG: dec.start[START_ALUREG] = 1'b1;
            CLS_ALUINM: dec.start[START_ALUINM] = 1'b1;
            CLS_MOV:    dec.start[START_MOV]    = 1'b1;
            default: begin
                dec.is_jmp     = (opcode == OP_JMP);
                dec.is_halt    = (opcode == OP_HALT);
                dec.is_illegal = (opcode != OP_JMP) && (opcode != OP_HALT);
            end
        endcase
    end

endmodule

// File: rtl/instr_fetch_dispatch_fsm.sv
// Fetch/decode/dispatch controller. Reads one instruction per PC, presents its
// operands, starts exactly one execution FSM and waits for its done. Jump,
// halt and illegal opcodes are resolved here without dispatching.
module instr_fetch_dispatch_fsm
    import instr_fetch_dispatch_fsm_pkg::*;
#(
    parameter int AW  = 8,
    parameter int OPW = 6,
    parameter int PW  = 6,
    parameter int IW  = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic [AW-1:0]      pc_addr,
    output logic               mem_req,
    input  logic [IW-1:0]      mem_data,
    input  logic               mem_ready,
    output logic [OPW-1:0]     opcode,
    output logic [PW-1:0]      parameter1,
    output logic [PW-1:0]      parameter2,
    output logic               donefetch,
    output logic [START_W-1:0] start,
    input  logic               exec_done,
    output logic               halted,
    output logic               illegal
);

    state_t         state;
    state_t         next_state;
    logic [AW-1:0]  pc;
    logic [IW-1:0]  ir;
    logic [AW-1:0]  jmp_target;
    decode_t        dec;

    // Operand fields are taken straight from the frozen instruction register
    assign opcode     = ir[IW-1 -: OPW];
    assign parameter1 = ir[2*PW-1 -: PW];
    assign parameter2 = ir[PW-1:0];
    assign pc_addr    = pc;
    assign jmp_target = AW'({parameter1, parameter2});

    instr_decoder u_decoder (
        .opcode (opcode),
        .dec    (dec)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and Moore outputs; run only steers completion into FETCH or IDLE
    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        donefetch  = 1'b0;
        start      = '0;
        halted     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run) next_state = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) next_state = ST_DECODE;
            end
            ST_DECODE: begin
                donefetch = 1'b1;
                if (dec.cls != CLS_CTRL) begin
                    next_state = ST_EXEC;
                end else if (dec.is_halt) begin
                    next_state = ST_HALT;
                end else begin
                    next_state = run ? ST_FETCH : ST_IDLE;
                end
            end
            ST_EXEC: begin
                donefetch = 1'b1;
                start     = dec.start;
                if (exec_done) next_state = run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Instruction capture on the ready edge, PC advance or jump in DECODE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= '0;
            ir <= '0;
        end else begin
            if (state == ST_FETCH && mem_ready) ir <= mem_data;
            if (state == ST_DECODE) pc <= dec.is_jmp ? jmp_target : pc + AW'(1);
        end
    end

    // Sticky flag for unknown control opcodes, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal <= 1'b0;
        end else if (state == ST_DECODE && dec.is_illegal) begin
            illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_fetch_dispatch_fsm.sv
// Self-checking bench: a vector table of instructions driven through the
// fetch/decode/exec handshake, a scoreboard of expected decode fields, and
// hand-written sequences for run drop, halt and asynchronous reset.
module tb_instr_fetch_dispatch_fsm;

    localparam int AW  = 8;
    localparam int OPW = 6;
    localparam int PW  = 6;
    localparam int IW  = 18;

    logic           clk = 1'b0;
    logic           rst;
    logic           run;
    logic [AW-1:0]  pc_addr;
    logic           mem_req;
    logic [IW-1:0]  mem_data;
    logic           mem_ready;
    logic [OPW-1:0] opcode;
    logic [PW-1:0]  parameter1;
    logic [PW-1:0]  parameter2;
    logic           donefetch;
    logic [2:0]     start;
    logic           exec_done;
    logic           halted;
    logic           illegal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0] opcode;
        logic [5:0] p1;
        logic [5:0] p2;
    } sb_t;

    typedef struct {
        logic [17:0] instr;
        int          wait_cycles;
        int          exec_cycles;
        logic [2:0]  exp_start;
        logic [7:0]  exp_next_pc;
        logic        exp_illegal;
    } vec_t;

    sb_t        sb_q[$];
    vec_t       vecs[10];
    logic [7:0] exp_pc;
    logic [5:0] last_op;

    instr_fetch_dispatch_fsm #(.AW(AW), .OPW(OPW), .PW(PW), .IW(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .pc_addr    (pc_addr),
        .mem_req    (mem_req),
        .mem_data   (mem_data),
        .mem_ready  (mem_ready),
        .opcode     (opcode),
        .parameter1 (parameter1),
        .parameter2 (parameter2),
        .donefetch  (donefetch),
        .start      (start),
        .exec_done  (exec_done),
        .halted     (halted),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Handshake invariants sampled every falling edge while out of reset
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            check("inv_start_onehot", 32'($countones(start) <= 1), 1);
            check("inv_start_needs_donefetch", 32'((start != 3'b000) && !donefetch), 0);
            check("inv_req_vs_donefetch", 32'(mem_req && donefetch), 0);
            check("inv_halt_no_req", 32'(halted && mem_req), 0);
        end
    end

    // One complete instruction: fetch (with optional wait), decode, optional exec
    task automatic do_instr(input logic [17:0] instr, input int wait_cycles, input int exec_cycles,
                            input logic [2:0] exp_start, input logic [7:0] next_pc, input bit drop_run);
        sb_t exp;
        int  lat;
        check("fetch_mem_req", mem_req, 1);
        check("fetch_pc_addr", pc_addr, exp_pc);
        for (int i = 0; i < wait_cycles; i++) begin
            @(posedge clk); @(negedge clk);
            check("wait_mem_req", mem_req, 1);
            check("wait_no_donefetch", donefetch, 0);
            check("wait_ir_frozen", opcode, last_op);
        end
        mem_data  = instr;
        mem_ready = 1'b1;
        exp.opcode = instr[17:12];
        exp.p1     = instr[11:6];
        exp.p2     = instr[5:0];
        sb_q.push_back(exp);
        lat = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            mem_ready = 1'b0;
            mem_data  = 18'h3ffff;
            lat++;
            if (donefetch) break;
        end
        check("decode_donefetch", donefetch, 1);
        check("decode_latency", lat, 1);
        exp = sb_q.pop_front();
        check("decode_opcode", opcode, exp.opcode);
        check("decode_parameter1", parameter1, exp.p1);
        check("decode_parameter2", parameter2, exp.p2);
        check("decode_start_zero", start, 0);
        last_op = exp.opcode;
        if (exec_cycles > 0) begin
            for (int i = 0; i < exec_cycles; i++) begin
                @(posedge clk); @(negedge clk);
                check("exec_start", start, exp_start);
                check("exec_donefetch", donefetch, 1);
                check("exec_pc_addr", pc_addr, next_pc);
                check("exec_ir_frozen", opcode, exp.opcode);
                if (drop_run && i == 0) run = 1'b0;
                if (i == exec_cycles - 1) exec_done = 1'b1;
            end
            @(posedge clk); @(negedge clk);
            exec_done = 1'b0;
        end else begin
            @(posedge clk); @(negedge clk);
        end
        check("post_start_zero", start, 0);
        check("post_donefetch_zero", donefetch, 0);
        check("post_pc_addr", pc_addr, next_pc);
        exp_pc = next_pc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{{6'b010000, 6'b000000, 6'b000011}, 0, 2, 3'b010, 8'h01, 1'b0};
        vecs[1] = '{{6'b000101, 6'b001010, 6'b000111}, 3, 1, 3'b001, 8'h02, 1'b0};
        vecs[2] = '{{6'b100011, 6'b111111, 6'b000000}, 1, 3, 3'b100, 8'h03, 1'b0};
        vecs[3] = '{{6'b110000, 6'b000000, 6'b000100}, 0, 0, 3'b000, 8'h04, 1'b0};
        vecs[4] = '{{6'b110101, 6'b010101, 6'b101010}, 0, 0, 3'b000, 8'h05, 1'b1};
        vecs[5] = '{{6'b110000, 6'b000011, 6'b111111}, 2, 0, 3'b000, 8'hFF, 1'b1};
        vecs[6] = '{{6'b000001, 6'b000010, 6'b000011}, 0, 1, 3'b001, 8'h00, 1'b1};
        vecs[7] = '{{6'b100000, 6'b000001, 6'b000010}, 0, 1, 3'b100, 8'h01, 1'b1};
        vecs[8] = '{{6'b110000, 6'b000010, 6'b000101}, 0, 0, 3'b000, 8'h85, 1'b1};
        vecs[9] = '{{6'b011111, 6'b101010, 6'b010101}, 1, 2, 3'b010, 8'h86, 1'b1};

        rst       = 1'b0;
        run       = 1'b0;
        mem_ready = 1'b0;
        mem_data  = '0;
        exec_done = 1'b0;
        exp_pc    = 8'h00;
        last_op   = 6'b000000;

        repeat (2) @(negedge clk);
        check("rst_pc_addr", pc_addr, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_opcode", opcode, 0);
        check("rst_parameter1", parameter1, 0);
        check("rst_parameter2", parameter2, 0);
        check("rst_donefetch", donefetch, 0);
        check("rst_start", start, 0);
        check("rst_halted", halted, 0);
        check("rst_illegal", illegal, 0);

        // Idle holds while run is low
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            check("idle_no_req", mem_req, 0);
        end
        run = 1'b1;
        @(posedge clk); @(negedge clk);

        for (int v = 0; v < 10; v++) begin
            do_instr(vecs[v].instr, vecs[v].wait_cycles, vecs[v].exec_cycles,
                     vecs[v].exp_start, vecs[v].exp_next_pc, 1'b0);
            check("illegal_flag", illegal, vecs[v].exp_illegal);
        end

        // run dropped during EXEC: instruction completes, controller parks in IDLE
        do_instr({6'b100001, 6'b000000, 6'b000001}, 0, 1, 3'b100, 8'h87, 1'b1);
        mem_ready = 1'b1;
        mem_data  = {6'b000010, 6'b000011, 6'b000100};
        exec_done = 1'b1;
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            check("idle_after_drop_req", mem_req, 0);
            check("idle_after_drop_donefetch", donefetch, 0);
            check("idle_after_drop_pc", pc_addr, 8'h87);
            check("idle_ignores_ready", opcode, 6'b100001);
        end
        mem_ready = 1'b0;
        exec_done = 1'b0;
        run       = 1'b1;
        @(posedge clk); @(negedge clk);

        // HALT: no further requests, stray strobes ignored
        do_instr({6'b111111, 6'b000000, 6'b000000}, 0, 0, 3'b000, 8'h88, 1'b0);
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            exec_done = i[1];
            @(posedge clk); @(negedge clk);
            check("halt_halted", halted, 1);
            check("halt_mem_req", mem_req, 0);
            check("halt_start", start, 0);
        end
        mem_ready = 1'b0;
        exec_done = 1'b0;
        check("halt_illegal_kept", illegal, 1);

        // Asynchronous reset out of HALT clears halted and illegal before any edge
        #2 rst = 1'b0;
        #1;
        check("arst_halted", halted, 0);
        check("arst_illegal", illegal, 0);
        check("arst_pc", pc_addr, 0);
        @(negedge clk);
        rst = 1'b1;
        run = 1'b1;
        @(posedge clk); @(negedge clk);
        exp_pc  = 8'h00;
        last_op = 6'b000000;

        // Reset mid-EXEC with start=001
        check("rf_mem_req", mem_req, 1);
        check("rf_pc_addr", pc_addr, 0);
        mem_data  = {6'b000000, 6'b000001, 6'b000010};
        mem_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        mem_ready = 1'b0;
        check("rf_decode_donefetch", donefetch, 1);
        @(posedge clk); @(negedge clk);
        check("rf_exec_start", start, 3'b001);
        check("rf_exec_pc", pc_addr, 8'h01);
        #2 rst = 1'b0;
        #1;
        check("arst_exec_start", start, 0);
        check("arst_exec_donefetch", donefetch, 0);
        check("arst_exec_pc", pc_addr, 0);
        check("arst_exec_opcode", opcode, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("resume_mem_req", mem_req, 1);
        check("resume_pc_addr", pc_addr, 0);

        // One more instruction after recovery
        do_instr({6'b010010, 6'b000111, 6'b000001}, 0, 1, 3'b010, 8'h01, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
